fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the instruction fetch front end.
//   fetch_state_e    : fetch FSM state encoding (IDLE, WAIT, DRAIN)
//   OP_*             : RV32I major opcodes, shared with ctrl_unit
//   RESET_PC_DEFAULT : default first fetch address after reset
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : empties the buffer (wins over push/pop)
//   push, push_pc/instr   : write an entry at the tail
//   pop                   : drop the head entry
//   full, empty, count    : occupancy status
//   head_pc, head_instr   : head entry (undefined contents when empty)
// A push on a full buffer is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_pc,
  input  logic [WIDTH-1:0]         push_instr,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_pc,
  output logic [WIDTH-1:0]         head_instr
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding requests to instruction
// memory, buffers returned words in fetch_fifo and presents the head to decode.
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req/addr            : registered fetch request (held until ack)
//   imem_ack/rdata           : memory response
//   redirect_en/pc           : taken branch/jump, flushes the buffer
//   stall                    : decode cannot accept the head instruction
//   instr_valid/instr/instr_pc/opcode : buffer head to decode/ctrl_unit
module fetch_unit
  import rv32_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [6:0]       opcode
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e     state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target_pc;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] head_pc;
  logic [WIDTH-1:0] head_instr;
  logic [CW:0]      occ_after;

  assign pc_inc    = fetch_pc + WIDTH'(4);
  assign target_pc = redirect_pc & ~WIDTH'(3);

  always_comb begin
    fifo_pop   = !fifo_empty && !stall;
    fifo_flush = redirect_en;
    fifo_push  = (state == WAIT) && imem_ack && !redirect_en;
    // Occupancy once this cycle's push and pop have both been applied.
    occ_after  = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_pc    (imem_addr),
    .push_instr (imem_rdata),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_en) begin
            fetch_pc <= target_pc;
          end else if (!fifo_full || fifo_pop) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (redirect_en) begin
            // Ack in the same cycle is dropped; otherwise the in-flight
            // response still has to be absorbed in DRAIN.
            fetch_pc <= target_pc;
            imem_req <= 1'b0;
            state    <= imem_ack ? IDLE : DRAIN;
          end else if (imem_ack) begin
            fetch_pc <= pc_inc;
            if (occ_after < (CW+1)'(DEPTH)) begin
              imem_addr <= pc_inc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (redirect_en) fetch_pc <= target_pc;
          if (imem_ack)    state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Head is forced to zero when empty so flushed/reset outputs are clean.
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : head_instr;
  assign instr_pc    = fifo_empty ? '0 : head_pc;
  assign opcode      = instr[6:0];

endmodule
